bp_me_wormhole_mem_responder: RTL and testbench

Memory-side endpoint of the mem-NoC wormhole link. It receives command packets as flits on the command link and reassembles them into one command for the local memory or cache. It then serializes the memory response into a response packet and routes it back to the sender's coordinate. It is the responder counterpart to the DMA link master in tile designs and sits in front of DRAM controllers or I/O devices.

---
 rtl/bp_me_wormhole_mem_responder.sv | 97 +++++++++
 tb/tb_bp_me_wormhole_mem_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bp_me_wormhole_mem_responder.sv
// bp_me_wormhole_mem_responder: reassembles wormhole command packets into memory commands and serializes responses back to the sender.
module bp_me_wormhole_mem_responder #(
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 8,
  parameter int len_width_p = 4,
  parameter int cid_width_p = 2,
  parameter int cmd_payload_width_p = 200,
  parameter int resp_payload_width_p = 200,
  parameter int link_width_lp = flit_width_p + 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [cord_width_p-1:0] my_cord_i,
  input  logic [link_width_lp-1:0] cmd_link_i,
  output logic [link_width_lp-1:0] cmd_link_o,
  input  logic [link_width_lp-1:0] resp_link_i,
  output logic [link_width_lp-1:0] resp_link_o,
  output logic [cmd_payload_width_p-1:0] mem_cmd_o,
  output logic mem_cmd_v_o,
  input  logic mem_cmd_yumi_i,
  input  logic [resp_payload_width_p-1:0] mem_resp_i,
  input  logic [len_width_p-1:0] mem_resp_len_i,
  input  logic mem_resp_v_i,
  output logic mem_resp_ready_o
);
  localparam int hdr_w_lp = 2*cord_width_p + len_width_p + cid_width_p;
  localparam int cmd_flits_lp = (hdr_w_lp + cmd_payload_width_p + flit_width_p - 1) / flit_width_p;
  localparam int resp_flits_lp = (hdr_w_lp + resp_payload_width_p + flit_width_p - 1) / flit_width_p;
  localparam int cmd_idx_w_lp = cmd_flits_lp > 1 ? $clog2(cmd_flits_lp) : 1;
  localparam int resp_idx_w_lp = resp_flits_lp > 1 ? $clog2(resp_flits_lp) : 1;
  localparam int resp_flat_w_lp = resp_flits_lp * flit_width_p;
  typedef enum logic [1:0] {e_rx, e_cmd, e_wait, e_tx} state_e;
  state_e state;
  logic [len_width_p-1:0] cnt, len_r, resp_len_r;
  logic [cid_width_p-1:0] cid_r;
  logic [cord_width_p-1:0] src_r;
  logic [cmd_flits_lp-1:0][flit_width_p-1:0] cmd_buf;
  logic [resp_flits_lp-1:0][flit_width_p-1:0] resp_buf;
  logic [cmd_flits_lp*flit_width_p-1:0] cmd_flat;
  logic [resp_flat_w_lp-1:0] resp_pkt;
  logic [flit_width_p-1:0] cmd_data;
  logic [len_width_p-1:0] rx_len;
  logic cmd_v, rx_ready, rx_last, tx_v, tx_go, tx_last;
  assign cmd_v = cmd_link_i[link_width_lp-1];
  assign cmd_data = cmd_link_i[flit_width_p:1];
  assign rx_ready = (state == e_rx) & ~reset_i;
  // Flit 0 carries the length itself, so the last-flit test must look at the live header.
  assign rx_len = (cnt == '0) ? cmd_data[cord_width_p +: len_width_p] : len_r;
  assign rx_last = (cnt == rx_len);
  assign tx_v = (state == e_tx);
  assign tx_go = tx_v & resp_link_i[0];
  assign tx_last = (cnt == resp_len_r);
  assign cmd_flat = cmd_buf;
  assign resp_pkt = resp_flat_w_lp'({mem_resp_i, my_cord_i, cid_r, mem_resp_len_i, src_r});
  assign cmd_link_o = {(flit_width_p + 1)'(0), rx_ready};
  assign resp_link_o = {tx_v, tx_v ? resp_buf[cnt[resp_idx_w_lp-1:0]] : flit_width_p'(0), 1'b0};
  assign mem_cmd_o = cmd_flat[hdr_w_lp +: cmd_payload_width_p];
  assign mem_cmd_v_o = (state == e_cmd);
  assign mem_resp_ready_o = (state == e_wait);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= e_rx;
      cnt <= '0;
      len_r <= '0;
      resp_len_r <= '0;
      cid_r <= '0;
      src_r <= '0;
    end else begin
      case (state)
        e_rx: if (cmd_v) begin
          if (cnt == '0) begin
            assert (rx_len < len_width_p'(cmd_flits_lp));
            for (int i = 1; i < cmd_flits_lp; i++) cmd_buf[i] <= '0;
            len_r <= rx_len;
            cid_r <= cmd_data[cord_width_p + len_width_p +: cid_width_p];
            src_r <= cmd_data[cord_width_p + len_width_p + cid_width_p +: cord_width_p];
          end
          cmd_buf[cnt[cmd_idx_w_lp-1:0]] <= cmd_data;
          cnt <= rx_last ? '0 : cnt + 1'b1;
          state <= rx_last ? e_cmd : e_rx;
        end
        e_cmd: state <= mem_cmd_yumi_i ? e_wait : e_cmd;
        e_wait: if (mem_resp_v_i) begin
          resp_buf <= resp_pkt;
          resp_len_r <= mem_resp_len_i;
          cnt <= '0;
          state <= e_tx;
        end
        e_tx: if (tx_go) begin
          cnt <= tx_last ? '0 : cnt + 1'b1;
          state <= tx_last ? e_rx : e_tx;
        end
        default: state <= e_rx;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_me_wormhole_mem_responder.sv
// tb_bp_me_wormhole_mem_responder: randomized packet-level check of the mem responder against a flit-slicing model.
module tb_bp_me_wormhole_mem_responder;
  logic clk = 0;
  logic reset_i;
  logic [7:0] my_cord;
  logic [65:0] cmd_link_i, cmd_link_o, resp_link_i, resp_link_o;
  logic [199:0] mem_cmd, mem_resp;
  logic mem_cmd_v, yumi, resp_v, resp_rdy;
  logic [3:0] resp_len;
  logic cmd_v, down_rdy;
  logic [63:0] cmd_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign cmd_link_i = {cmd_v, cmd_data, 1'b0};
  assign resp_link_i = {1'b0, 64'h0, down_rdy};
  bp_me_wormhole_mem_responder dut (
    .clk_i(clk), .reset_i(reset_i), .my_cord_i(my_cord),
    .cmd_link_i(cmd_link_i), .cmd_link_o(cmd_link_o),
    .resp_link_i(resp_link_i), .resp_link_o(resp_link_o),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_yumi_i(yumi),
    .mem_resp_i(mem_resp), .mem_resp_len_i(resp_len), .mem_resp_v_i(resp_v),
    .mem_resp_ready_o(resp_rdy)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [199:0] rnd_pl();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[199:0];
  endfunction
  // Sends flits 0..len back-to-back, then expects the command one cycle later and consumes it.
  task automatic do_cmd(input logic [3:0] len, input logic [1:0] cid, input logic [7:0] src, input logic [199:0] pl);
    logic [255:0] pkt, m, exp;
    int n;
    pkt = {34'b0, pl, src, cid, len, 8'h10};
    for (int f = 0; f <= int'(len); f++) begin
      cmd_v = 1;
      cmd_data = pkt[f*64 +: 64];
      n = 0;
      while (!cmd_link_o[0] && n < 50) begin @(negedge clk); n++; end
      if (n == 50) check("cmd_ready_timeout", 256'(n), 0);
      @(negedge clk);
    end
    cmd_v = 0;
    m = '1;
    if (len < 3) m = (256'd1 << ((int'(len) + 1) * 64)) - 256'd1;
    exp = pkt & m;
    exp = 256'(exp[221:22]);
    check("cmd_v", 256'(mem_cmd_v), 1);
    check("cmd_rdy_low", 256'(cmd_link_o[0]), 0);
    check("cmd_pl", 256'(mem_cmd), exp);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("cmd_hold", 256'(mem_cmd), exp);
    end
    yumi = 1;
    @(negedge clk);
    yumi = 0;
    check("cmd_v_clear", 256'(mem_cmd_v), 0);
    check("resp_rdy", 256'(resp_rdy), 1);
  endtask
  // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random; busy keeps junk command flits offered.
  task automatic do_resp(input logic [3:0] len, input logic [7:0] src, input logic [1:0] cid, input logic [7:0] cord,
                         input logic [199:0] pl, input int mode, input bit busy);
    logic [255:0] pkt;
    int acc, n;
    bit r;
    my_cord = cord;
    pkt = {34'b0, pl, cord, cid, len, src};
    if (busy) begin
      cmd_v = 1;
      cmd_data = {$urandom, $urandom};
      @(negedge clk);
      check("busy_wait_rdy", 256'(cmd_link_o[0]), 0);
      check("busy_no_cmd", 256'(mem_cmd_v), 0);
    end
    resp_v = 1;
    mem_resp = pl;
    resp_len = len;
    @(negedge clk);
    resp_v = 0;
    mem_resp = rnd_pl();
    my_cord = 8'(~cord);
    acc = 0;
    n = 0;
    while (acc <= int'(len) && n < 200) begin
      check("tx_v", 256'(resp_link_o[65]), 1);
      check("tx_flit", 256'(resp_link_o[64:1]), 256'(pkt[acc*64 +: 64]));
      if (busy) check("busy_tx_rdy", 256'(cmd_link_o[0]), 0);
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 3 == 0) : 1'($urandom_range(0, 1));
      down_rdy = r;
      if (r) acc++;
      if (acc > int'(len)) cmd_v = 0;
      @(negedge clk);
      n++;
    end
    down_rdy = 0;
    check("tx_count", 256'(acc), 256'(int'(len) + 1));
    check("tx_done_v", 256'(resp_link_o[65]), 0);
    check("back_rx", 256'(cmd_link_o[0]), 1);
  endtask
  initial begin
    logic [199:0] pl;
    reset_i = 1; cmd_v = 0; cmd_data = '0; down_rdy = 0; yumi = 0; resp_v = 0;
    mem_resp = '0; resp_len = '0; my_cord = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_rdy", 256'(cmd_link_o[0]), 0);
    check("rst_resp_v", 256'(resp_link_o[65]), 0);
    check("rst_resp_data", 256'(resp_link_o[64:1]), 0);
    check("rst_mem_cmd_v", 256'(mem_cmd_v), 0);
    check("rst_resp_rdy", 256'(resp_rdy), 0);
    reset_i = 0;
    @(negedge clk);
    check("idle_cmd_rdy", 256'(cmd_link_o[0]), 1);
    pl = rnd_pl();
    do_cmd(4'd3, 2'd2, 8'h21, pl);
    do_resp(4'd3, 8'h21, 2'd2, 8'h05, rnd_pl(), 1, 0);
    do_cmd(4'd1, 2'd1, 8'h33, rnd_pl());
    do_resp(4'd0, 8'h33, 2'd1, 8'h07, rnd_pl(), 2, 1);
    do_cmd(4'd0, 2'd3, 8'h44, rnd_pl());
    do_resp(4'd2, 8'h44, 2'd3, 8'h09, rnd_pl(), 0, 1);
    cmd_v = 1;
    for (int f = 0; f < 2; f++) begin
      cmd_data = {$urandom, $urandom};
      cmd_data[11:8] = 4'd3;
      @(negedge clk);
    end
    cmd_v = 0;
    reset_i = 1;
    @(negedge clk);
    check("mid_rst_rdy", 256'(cmd_link_o[0]), 0);
    @(negedge clk);
    reset_i = 0;
    repeat (3) @(negedge clk);
    check("abort_no_cmd", 256'(mem_cmd_v), 0);
    check("abort_no_tx", 256'(resp_link_o[65]), 0);
    do_cmd(4'd3, 2'd2, 8'h21, rnd_pl());
    do_resp(4'd3, 8'h21, 2'd2, 8'h05, rnd_pl(), 2, 0);
    for (int k = 0; k < 20; k++) begin
      logic [3:0] l;
      logic [1:0] c;
      logic [7:0] s;
      l = 4'($urandom_range(0, 3));
      c = 2'($urandom);
      s = 8'($urandom);
      do_cmd(l, c, s, rnd_pl());
      do_resp(4'($urandom_range(0, 3)), s, c, 8'($urandom), rnd_pl(), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
